// File: rtl/seq_pkg.sv
// Shared encodings and defaults for the sequence pattern transmitter
// and the sequence-detector benches that consume its stream.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } seq_state_t;

  localparam int   DEF_WIDTH = 4;
  localparam int   DEF_GAP   = 1;
  localparam int   CNT_W     = 4;
  localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with zero flag; used for bit and gap counts.
// Decrement saturates at zero.
module seq_bit_counter
  import seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// MSB-first word serializer with post-word gap.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] BIT_LD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP - 1);
  localparam logic             GAP_ON = (GAP > 0);
  localparam seq_state_t       TAIL   = GAP_ON ? ST_GAP : ST_IDLE;

  seq_state_t       state, nstate;
  logic [WIDTH-1:0] sr, sr_n;
  logic             xv_n;
  logic             accept;
  logic             bit_ld, bit_dec, bit_zero;
  logic             gap_ld, gap_dec, gap_zero;

`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (reset) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^data_in;
    end
  end
`endif

  assign data_ready = (state == ST_IDLE) && !reset;
  assign accept     = data_valid && data_ready;
  assign busy       = (state != ST_IDLE);
  // x is the register MSB; zeros shift in behind the word
  assign x          = sr[WIDTH-1];

`ifdef SEQ_PATTERN_TX_PARITY_EN
  assign done = (state == ST_PARITY);
`else
  assign done = (state == ST_SHIFT) && bit_zero;
`endif

  always_comb begin
    nstate  = state;
    sr_n    = sr;
    xv_n    = 1'b0;
    bit_ld  = 1'b0;
    bit_dec = 1'b0;
    gap_ld  = 1'b0;
    gap_dec = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          nstate = ST_SHIFT;
          sr_n   = data_in;
          xv_n   = 1'b1;
          bit_ld = 1'b1;
        end
      end
      ST_SHIFT: begin
        sr_n    = {sr[WIDTH-2:0], IDLE_LVL};
        bit_dec = 1'b1;
        xv_n    = !bit_zero;
        if (bit_zero) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
          nstate = ST_PARITY;
          sr_n   = {par, {(WIDTH-1){IDLE_LVL}}};
          xv_n   = 1'b1;
`else
          nstate = TAIL;
          gap_ld = GAP_ON;
`endif
        end
      end
`ifdef SEQ_PATTERN_TX_PARITY_EN
      ST_PARITY: begin
        sr_n   = {sr[WIDTH-2:0], IDLE_LVL};
        nstate = TAIL;
        gap_ld = GAP_ON;
      end
`endif
      ST_GAP: begin
        gap_dec = 1'b1;
        if (gap_zero) begin
          nstate = ST_IDLE;
        end
      end
      default: begin
        nstate = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      sr      <= {WIDTH{IDLE_LVL}};
      x_valid <= 1'b0;
    end else begin
      state   <= nstate;
      sr      <= sr_n;
      x_valid <= xv_n;
    end
  end

  seq_bit_counter #(.W(CNT_W)) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (bit_ld),
    .load_val (BIT_LD),
    .dec      (bit_dec),
    .zero     (bit_zero)
  );

  seq_bit_counter #(.W(CNT_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_ld),
    .load_val (GAP_LD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx (GAP=1 and GAP=0 instances).
// Expectations follow SEQ_PATTERN_TX_PARITY_EN when defined.
module tb_seq_pattern_tx;

  localparam int W = 4;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif

  typedef struct {
    logic [W-1:0] data;
    logic         par;
    string        name;
  } vec_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] din, din0;
  logic         dv, dv0;
  logic         dr, dr0;
  logic         x, x0;
  logic         xv, xv0;
  logic         busy, busy0;
  logic         done, done0;

  int nvec = 0;
  int nerr = 0;

  logic       det_on = 1'b0;
  logic [1:0] ds = 2'd0;
  int         zc = 0;

  seq_pattern_tx #(.WIDTH(W), .GAP(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (din),
    .data_valid (dv),
    .data_ready (dr),
    .x          (x),
    .x_valid    (xv),
    .busy       (busy),
    .done       (done)
  );

  seq_pattern_tx #(.WIDTH(W), .GAP(0)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (din0),
    .data_valid (dv0),
    .data_ready (dr0),
    .x          (x0),
    .x_valid    (xv0),
    .busy       (busy0),
    .done       (done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // non-overlapping Mealy detector for 1011 on the valid bits
  always @(negedge clk) begin
    if (det_on && xv) begin
      case (ds)
        2'd0: ds <= x ? 2'd1 : 2'd0;
        2'd1: ds <= x ? 2'd1 : 2'd2;
        2'd2: ds <= x ? 2'd3 : 2'd0;
        default: begin
          if (x) begin
            zc <= zc + 1;
            ds <= 2'd0;
          end else begin
            ds <= 2'd2;
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!dr && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", 16'(dr), 16'd1);
  endtask

  task automatic send_check(input logic [W-1:0] d, input logic p,
                            input string nm, input bit inj);
    logic eb;
    wait_ready();
    din = d;
    dv  = 1'b1;
    step();
    dv  = 1'b0;
    din = ~d;
    for (int k = 0; k < L; k++) begin
      eb = (k < W) ? d[W-1-k] : p;
      chk($sformatf("%s_b%0d", nm, k), 16'({x, xv, done}),
          16'({eb, 1'b1, k == L - 1}));
      if (inj && k == 1) begin
        din = 4'b1111;
        dv  = 1'b1;
      end else begin
        dv  = 1'b0;
      end
      step();
    end
    chk({nm, "_gap"}, 16'({x, xv, done, busy}), 16'b0001);
    step();
    chk({nm, "_rdy"}, 16'({dr, busy}), 16'b10);
  endtask

  vec_t tv[6];

  initial begin
    logic [W-1:0] w1, w2;
    logic         p1, p2;
    logic         eb, ev, ed;

    tv[0] = '{4'b1011, 1'b1, "v1011"};
    tv[1] = '{4'b0110, 1'b0, "v0110"};
    tv[2] = '{4'b1000, 1'b1, "v1000"};
    tv[3] = '{4'b0001, 1'b1, "v0001"};
    tv[4] = '{4'b1111, 1'b0, "v1111"};
    tv[5] = '{4'b0000, 1'b0, "v0000"};

    reset = 1'b1;
    dv    = 1'b1;
    din   = 4'b1011;
    dv0   = 1'b1;
    din0  = 4'b1011;
    step();
    step();
    chk("rst_ready", 16'({dr, dr0}), 16'b00);
    chk("rst_out", 16'({x, xv, done, busy}), 16'b0000);
    step();
    chk("rst_hold", 16'({x, xv, done, busy, busy0}), 16'b00000);
    reset = 1'b0;
    dv    = 1'b0;
    dv0   = 1'b0;
    step();
    chk("post_rst", 16'({dr, busy, xv}), 16'b100);

    for (int i = 0; i < 6; i++) begin
      send_check(tv[i].data, tv[i].par, tv[i].name, 1'b0);
    end

    // a word offered while busy is dropped, not queued
    send_check(4'b1011, 1'b1, "inject", 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("inject_idle%0d", k), 16'({xv, busy}), 16'b00);
      step();
    end

    // GAP=0 back-to-back with data_valid held high
    w1   = 4'b1011;
    p1   = 1'b1;
    w2   = 4'b0110;
    p2   = 1'b0;
    din0 = w1;
    dv0  = 1'b1;
    step();
    din0 = w2;
    for (int c = 0; c <= 2 * L; c++) begin
      if (c < L) begin
        eb = (c < W) ? w1[W-1-c] : p1;
        ev = 1'b1;
        ed = (c == L - 1);
      end else if (c == L) begin
        eb = 1'b0;
        ev = 1'b0;
        ed = 1'b0;
      end else begin
        eb = (c - L - 1 < W) ? w2[W-1-(c-L-1)] : p2;
        ev = 1'b1;
        ed = (c == 2 * L);
      end
      chk($sformatf("b2b_c%0d", c), 16'({x0, xv0, done0}),
          16'({eb, ev, ed}));
      if (c == L + 1) begin
        dv0 = 1'b0;
      end
      step();
    end
    chk("b2b_end", 16'({xv0, busy0, dr0}), 16'b001);

    // reset in the cycle carrying the 2nd bit
    wait_ready();
    din = 4'b1011;
    dv  = 1'b1;
    step();
    dv  = 1'b0;
    chk("abort_b0", 16'({x, xv, done}), 16'b110);
    step();
    chk("abort_b1", 16'({x, xv, done}), 16'b010);
    reset = 1'b1;
    step();
    chk("abort_rst", 16'({x, xv, done, busy, dr}), 16'b00000);
    reset = 1'b0;
    step();
    chk("abort_rel", 16'({dr, busy, xv, done}), 16'b1000);
    step();
    chk("abort_idle", 16'({dr, busy, xv, done}), 16'b1000);

    // loopback into the detector: 1011, 0100, 1011
    det_on = 1'b1;
    send_check(4'b1011, 1'b1, "lb0", 1'b0);
    send_check(4'b0100, 1'b1, "lb1", 1'b0);
    send_check(4'b1011, 1'b1, "lb2", 1'b0);
    det_on = 1'b0;
    step();
    chk("loopback_z", 16'(zc), 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter WIDTH, default 4: number of bits per serialized word (legal 2..16).
REQ-002 Parameter GAP, default 1: number of forced-zero cycles after each word (legal 0..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  WIDTH  word to transmit, MSB first.
REQ-006 data_valid  input  1  data_in is valid.
REQ-007 data_ready  output  1  block can accept a word this cycle.
REQ-008 x  output  1  serial bit stream, registered; idle level 0.
REQ-009 x_valid  output  1  high while x carries a word bit (or parity bit).
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse coincident with the final bit of a word.

Function
REQ-012 FSM states are IDLE, SHIFT, PARITY (macro only), and GAP.
REQ-013 data_ready SHALL equal (state == IDLE) and SHALL be low during reset.
REQ-014 A transfer occurs at the rising edge where data_valid && data_ready; data_in is captured into a WIDTH-bit shift register and a bit counter is loaded with WIDTH-1.
REQ-015 Latency: for a transfer at edge N, x = data_in[WIDTH-1] with x_valid=1 during cycle N+1; the remaining bits follow MSB to LSB on consecutive cycles, with no stalls.
REQ-016 SHIFT: each edge shifts the register left and decrements the counter; when the counter is 0 the next state is PARITY if the macro is enabled, otherwise GAP if GAP>0, otherwise IDLE.
REQ-017 done SHALL be 1 only in the cycle carrying the final bit: the LSB, or the parity bit when the macro is enabled.
REQ-018 GAP: x=0, x_valid=0, busy=1 for exactly GAP cycles, then IDLE.
REQ-019 Minimum spacing between the last bit of one word and the first bit of the next is GAP+1 zero cycles (the GAP cycles plus the IDLE accept cycle).
REQ-020 data_valid and data_in are ignored while busy; no word is queued.
REQ-021 In IDLE: x=0, x_valid=0, done=0.
REQ-022 A data_in change after capture SHALL NOT affect the word in flight.

Reset
REQ-023 While reset=1 at an edge: state=IDLE, shift register=0, counters=0, x=0, x_valid=0, done=0, busy=0.
REQ-024 reset asserted mid-word or mid-gap aborts the word immediately, with no done pulse; the first edge after release is a normal IDLE cycle with data_ready=1.
REQ-025 reset takes priority over a simultaneous data_valid; that word is dropped.

Configuration
REQ-026 Macro SEQ_PATTERN_TX_PARITY_EN: when defined, one even-parity bit (XOR of the captured word) is appended after the LSB with x_valid=1, so a word occupies WIDTH+1 cycles.
REQ-027 When SEQ_PATTERN_TX_PARITY_EN is not defined, the PARITY state and its logic are absent and a word occupies WIDTH cycles.

Structure
REQ-028 Shared package seq_pkg holds the FSM state encoding (IDLE=0, SHIFT=1, PARITY=2, GAP=3), default WIDTH/GAP constants, and the idle line level constant (0), for reuse by the sequence-detector benches.
REQ-029 One sub-module, seq_bit_counter, is a loadable down-counter with a zero flag; it is instantiated twice, once for the bit count and once for the gap count.

Verification
REQ-030 WIDTH=4, GAP=1, no macro; send 4'b1011 at edge N -> x=1,0,1,1 in cycles N+1..N+4, x_valid=1 in those cycles, done=1 only in N+4, x=0 in N+5, data_ready=1 in N+6.
REQ-031 Back-to-back: data_valid held high with 4'b1011 then 4'b0110, GAP=0 -> streams are 1011 and 0110 separated by exactly one zero cycle.
REQ-032 data_valid pulsed with 4'b1111 during SHIFT -> ignored; output stays the in-flight word and no extra word follows.
REQ-033 reset asserted in the cycle carrying the 2nd bit -> x=0 and x_valid=0 next cycle, no done, data_ready=1 after release.
REQ-034 SEQ_PATTERN_TX_PARITY_EN defined, 4'b1011 -> x=1,0,1,1,1 with done on the 5th bit; 4'b0110 -> parity bit 0.
REQ-035 Loopback: stream 1011, 0100, 1011 into the team's non-overlapping Mealy detector -> detector z asserts exactly twice, on each final 1 of 1011.
